// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Buffers parallel words from a valid/ready source in a small FIFO and
//   serialises each one as a framed bit stream: start bit (0), WIDTH data
//   bits LSB-first, optional even-parity bit, stop bit (1). The line idles high.
//   Consecutive queued words go out back-to-back with no idle gap.
//
// Ports
//   CLK       in   1             single clock, all logic on posedge
//   RESET     in   1             synchronous, active-high reset
//   IN_DATA   in   WIDTH         word to transmit
//   IN_VALID  in   1             IN_DATA valid
//   IN_READY  out  1             FIFO can accept (combinational from LEVEL and RESET)
//   DATA_OUT  out  1             registered serial line
//   BUSY      out  1             registered, high while a frame is on DATA_OUT
//   LEVEL     out  clog2(D)+1    registered FIFO occupancy, 0..DEPTH
module serial_frame_tx #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned PARITY_EN    = 1
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [WIDTH-1:0]         IN_DATA,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   output logic                     DATA_OUT,
   output logic                     BUSY,
   output logic [$clog2(DEPTH):0]   LEVEL
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [WIDTH-1:0]    head_c;

   logic [TMR_W-1:0]    timer;
   logic [CNT_W-1:0]    bit_cnt;
   logic [WIDTH-1:0]    shift;
   logic                par;

   logic                push_c;
   logic                pop_c;
   logic                bit_done_c;
   logic                last_bit_c;
   logic                line_c;

   // Ready looks only at registered occupancy: a full FIFO refuses a push
   // even in the cycle that pops it.
   assign IN_READY   = !RESET && (LEVEL != LVL_W'(DEPTH));
   assign push_c     = IN_VALID && IN_READY;
   assign head_c     = mem[rd_ptr];
   assign bit_done_c = (timer == TMR_W'(CLKS_PER_BIT - 1));
   assign last_bit_c = (bit_cnt == CNT_W'(WIDTH - 1));

   // FIFO storage; not reset, contents are qualified by LEVEL.
   always_ff @(posedge CLK) begin
      if (push_c) begin
         mem[wr_ptr] <= IN_DATA;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         LEVEL  <= '0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_c, pop_c})
            2'b10:   LEVEL <= LEVEL + LVL_W'(1);
            2'b01:   LEVEL <= LEVEL - LVL_W'(1);
            default: ;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state, pop request and line value for the current bit.
   always_comb begin
      state_nxt = state;
      pop_c     = 1'b0;
      line_c    = 1'b1;
      case (state)
         S_IDLE: begin
            line_c = 1'b1;
            if (LEVEL != '0) begin
               pop_c     = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            line_c = 1'b0;
            if (bit_done_c) begin
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            line_c = shift[0];
            if (bit_done_c && last_bit_c) begin
               state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            line_c = par;
            if (bit_done_c) begin
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            line_c = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (bit_done_c) begin
               if (LEVEL != '0) begin
                  pop_c     = 1'b1;
                  state_nxt = S_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Bit timer, data bit counter, shift register and parity of the popped word.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         timer   <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         par     <= 1'b0;
      end else begin
         if (state == S_IDLE || bit_done_c) begin
            timer <= '0;
         end else begin
            timer <= timer + TMR_W'(1);
         end

         if (pop_c) begin
            shift <= head_c;
            par   <= ^head_c;
         end else if (state == S_DATA && bit_done_c) begin
            shift <= shift >> 1;
         end

         if (state == S_DATA && bit_done_c) begin
            bit_cnt <= last_bit_c ? '0 : bit_cnt + CNT_W'(1);
         end
      end
   end

   // Registered line and busy flag, aligned with each other.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         DATA_OUT <= 1'b1;
         BUSY     <= 1'b0;
      end else begin
         DATA_OUT <= line_c;
         BUSY     <= (state != S_IDLE);
      end
   end

endmodule
